// File: rtl/instruction_fetch.sv
// Instruction fetch with prefetch queue, redirect and optional halt-on-opcode.
// Define IFETCH_HALT_EN to stop fetching after queuing HALT_OPCODE.
module instruction_fetch #(
  parameter int         DEPTH       = 4,
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [7:0] instr_out,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  output logic       halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [7:0]    pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   q [DEPTH];
  logic          pop;
  logic          push;
  logic          stop;

  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  assign push        = !redirect_valid && !stop &&
                       ((count != FULL) || pop);

  // Head is forced to zero when empty so reset shows 00/00
  assign {instr_pc, instr_out} = instr_valid ? q[rd_ptr] : 16'h0000;

  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= {pc, imem_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 8'd1;
        wr_ptr <= wr_ptr + PONE;
      end
      if (pop) rd_ptr <= rd_ptr + PONE;
      case ({push, pop})
        2'b10:   count <= count + CONE;
        2'b01:   count <= count - CONE;
        default: count <= count;
      endcase
    end
  end

`ifdef IFETCH_HALT_EN
  logic halt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      halt_q <= 1'b0;
    else if (redirect_valid)
      halt_q <= 1'b0;
    else if (push && (imem_data == HALT_OPCODE))
      halt_q <= 1'b1;
  end

  assign halted = halt_q;
  assign stop   = halt_q;
`else
  logic unused_halt;

  assign unused_halt = ^HALT_OPCODE;
  assign halted      = 1'b0;
  assign stop        = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed fetch, stall, redirect,
// wrap, halt and reset scenarios against a byte-array memory model.
module tb_instruction_fetch;

  logic       clk;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] instr_out;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       halted;

  logic [7:0]  tbmem [256];
  logic [15:0] exp_q [$];
  logic [15:0] exp_e;
  int          n_chk;
  int          n_fail;
  int          sb_hits;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  assign imem_data = tbmem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input int n);
    logic [7:0] p;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      p = a + 8'(i);
      exp_q.push_back({p, tbmem[p]});
    end
  endtask

  task automatic redirect(input logic [7:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
    load(a, 40);
  endtask

  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      n_chk++;
      sb_hits++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got pc=%h instr=%h expected none",
                 instr_pc, instr_out);
      end else begin
        exp_e = exp_q.pop_front();
        if ({instr_pc, instr_out} !== exp_e) begin
          n_fail++;
          $display("FAIL sb_entry: got pc=%h instr=%h expected pc=%h instr=%h",
                   instr_pc, instr_out, exp_e[15:8], exp_e[7:0]);
        end
      end
    end
  end

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    sb_hits        = 0;
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    for (int i = 0; i < 256; i++) tbmem[i] = 8'(i + 1);

    #12;
    chk("rst_valid", {15'd0, instr_valid}, 16'h0000);
    chk("rst_addr", {8'd0, imem_addr}, 16'h0000);
    chk("rst_head", {instr_pc, instr_out}, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'h0000);

    // Release and stream with ready high
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    load(8'h00, 40);
    chk("valid_before_edge", {15'd0, instr_valid}, 16'h0000);
    tick();
    chk("first_valid", {15'd0, instr_valid}, 16'h0001);
    chk("first_head", {instr_pc, instr_out}, 16'h0001);
    repeat (5) tick();

    // Stall until the queue saturates
    instr_ready = 1'b0;
    redirect(8'h00);
    repeat (10) tick();
    chk("full_addr", {8'd0, imem_addr}, 16'h0004);
    chk("full_head", {instr_pc, instr_out}, 16'h0001);
    instr_ready = 1'b1;
    repeat (8) tick();

    // Redirect while full
    instr_ready = 1'b0;
    repeat (6) tick();
    redirect(8'h40);
    chk("flush_valid", {15'd0, instr_valid}, 16'h0000);
    tick();
    chk("redir_head", {instr_pc, instr_out}, 16'h4041);
    chk("redir_one_push", {8'd0, imem_addr}, 16'h0041);
    instr_ready = 1'b1;
    repeat (4) tick();

    // Redirect with ready high, PC wraps past FF
    redirect(8'hFE);
    tick();
    chk("wrap_head", {8'd0, instr_pc}, 16'h00FE);
    repeat (5) tick();

    // Back-to-back redirects, only the last sticks
    redirect_valid = 1'b1;
    redirect_pc    = 8'h10;
    tick();
    redirect_pc    = 8'h20;
    tick();
    redirect_valid = 1'b0;
    load(8'h20, 40);
    tick();
    chk("b2b_head", {instr_pc, instr_out}, 16'h2021);
    repeat (3) tick();

    // Halt opcode at address 05
    tbmem[5] = 8'hFF;
    redirect(8'h00);
`ifdef IFETCH_HALT_EN
    load(8'h00, 6);
`endif
    repeat (12) tick();
`ifdef IFETCH_HALT_EN
    chk("halt_set", {15'd0, halted}, 16'h0001);
    chk("halt_addr", {8'd0, imem_addr}, 16'h0006);
    chk("halt_drained", {15'd0, instr_valid}, 16'h0000);
    tbmem[5] = 8'h06;
    redirect(8'h00);
    chk("halt_clear", {15'd0, halted}, 16'h0000);
    tick();
    chk("halt_restart", {instr_pc, instr_out}, 16'h0001);
`else
    chk("nohalt", {15'd0, halted}, 16'h0000);
    chk("nohalt_addr", {8'd0, imem_addr}, 16'h000C);
    tbmem[5] = 8'h06;
`endif
    repeat (3) tick();

    // Asynchronous reset with a full queue
    instr_ready = 1'b0;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid", {15'd0, instr_valid}, 16'h0000);
    chk("arst_addr", {8'd0, imem_addr}, 16'h0000);
    chk("arst_head", {instr_pc, instr_out}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    load(8'h00, 40);
    tick();
    chk("arst_restart", {instr_pc, instr_out}, 16'h0001);
    repeat (4) tick();

    chk("sb_activity", {15'd0, (sb_hits >= 20)}, 16'h0001);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the prefetch queue depth in entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 8'h00, meaning the first fetch address after reset.
REQ-003 The block SHALL have parameter HALT_OPCODE, default 8'hFF, meaning the instruction byte that stops fetch (used only under IFETCH_HALT_EN).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port imem_addr, output, 8 bits: address to the instruction memory, driven from the registered PC.
REQ-007 The block SHALL have port imem_data, input, 8 bits: instruction byte returned combinationally by the memory in the same cycle.
REQ-008 The block SHALL have port instr_out, output, 8 bits: instruction at the queue head.
REQ-009 The block SHALL have port instr_pc, output, 8 bits: fetch address of instr_out.
REQ-010 The block SHALL have port instr_valid, output, 1 bit: high when the queue is non-empty.
REQ-011 The block SHALL have port instr_ready, input, 1 bit: the consumer accepts the head entry.
REQ-012 The block SHALL have port redirect_valid, input, 1 bit: the consumer requests a fetch restart (branch or jump).
REQ-013 The block SHALL have port redirect_pc, input, 8 bits: the restart address.
REQ-014 The block SHALL have port halted, output, 1 bit: fetch is stopped on HALT_OPCODE.

Function
REQ-015 The block SHALL push {imem_addr, imem_data} into the queue and set pc <= pc+1 in any cycle where a push is allowed.
REQ-016 A push SHALL be allowed when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle, with no redirect and halted low.
REQ-017 A pop SHALL occur when instr_valid and instr_ready are both high; an empty pop SHALL be impossible.
REQ-018 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-019 The PC SHALL increment modulo 256 (8'hFF -> 8'h00) with no flag and no stall.
REQ-020 instr_out and instr_pc SHALL be driven directly from the queue head, with no extra register stage.
REQ-021 On redirect_valid, the next edge SHALL empty the queue, load pc <= redirect_pc, clear halted, and perform no push.
REQ-022 Redirect SHALL take priority over push and pop; a head handshake in the redirect cycle counts as consumed, then is flushed.
REQ-023 Fetch latency SHALL be one cycle: instr_valid is high with instr_pc==redirect_pc in the cycle after a redirect edge.
REQ-024 Back-to-back redirects SHALL each restart fetch; only the last one takes effect.
REQ-025 The queue pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH and never overflow.

Reset
REQ-026 While rst_n is low, the block SHALL set pc=RESET_PC, count=0, pointers=0, instr_valid=0, halted=0, imem_addr=RESET_PC, and instr_out/instr_pc=8'h00.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries immediately.
REQ-028 The first push SHALL occur on the first rising clk edge after rst_n deasserts.

Configuration
REQ-029 With IFETCH_HALT_EN defined, pushing an entry whose data equals HALT_OPCODE SHALL set halted=1 at that edge.
REQ-030 Under IFETCH_HALT_EN, the halt entry SHALL be queued, and pushes SHALL stop until redirect or reset.
REQ-031 Under IFETCH_HALT_EN, queued entries SHALL still drain normally while halted=1.
REQ-032 Without IFETCH_HALT_EN, halted SHALL be tied to 0, HALT_OPCODE SHALL be ignored, and fetch SHALL be continuous.

Verification
REQ-033 Reset release with memory bytes 01,02,03 at 0..2 and instr_ready=1 -> instr_valid rises after the 1st edge; outputs (pc,instr) (00,01),(01,02),(02,03) on consecutive cycles.
REQ-034 instr_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4, imem_addr holds 8'h04; on ready=1, entries 0..3 pop in order and fetch resumes.
REQ-035 Redirect to 8'h40 while the queue is full -> next cycle instr_pc=8'h40, count=1, and no old entry appears.
REQ-036 Redirect to 8'hFE with ready=1 -> instr_pc sequence FE, FF, 00, 01.
REQ-037 IFETCH_HALT_EN, FF at address 05 -> halted=1 after pushing 05 and entries 00..05 drain; redirect to 00 -> halted=0 and fetch restarts.
REQ-038 rst_n pulsed low asynchronously mid-stream with a full queue -> instr_valid=0 immediately; after release, fetch restarts at RESET_PC.
